run_controller: RTL and testbench
=================================

Name: run_controller

Overview:
Synthesizable run/halt supervisor for the processor.
- On a START request it holds the processor in reset for a fixed number of cycles, then releases it and counts execution cycles.
- It detects the processor's HALT rising edge, extends the run for a fixed drain period, and reports DONE.
- If HALT never arrives it reports TIMEOUT and re-asserts processor reset.
- It sits between the board-level control logic and the processor's CLK/RST_bar/HALT pins.

Parameters:
RESET_CYCLES, 10, cycles CPU_RST_bar is held low after START (must be >= 1)
POST_HALT_CYCLES, 5, cycles the processor keeps running after the HALT rising edge before DONE (0 allowed)
TIMEOUT_CYCLES, 2500000, run cycles allowed before TIMEOUT; 0 disables the timeout
CYCLE_WIDTH, 32, width of the CYCLES counter; TIMEOUT_CYCLES must be < 2**CYCLE_WIDTH

Ports:
CLK  input  1  system clock; all state updates on posedge
RST_bar  input  1  synchronous active-low reset
START  input  1  run request, sampled each cycle; acted on only in IDLE, DONE or TIMEOUT
HALT  input  1  processor HALT line, same clock domain
CPU_RST_bar  output  1  processor reset, active low, registered
RUNNING  output  1  high in RUN and DRAIN states
DONE  output  1  high in DONE state
TIMED_OUT  output  1  high in TIMEOUT state
CYCLES  output  CYCLE_WIDTH  run cycle count since reset release, registered

Behaviour:
- Reset is synchronous and active-low: RST_bar low at a CLK posedge forces the following, overriding any state, including mid-run:
  - state=IDLE
  - CPU_RST_bar=0, RUNNING=0, DONE=0, TIMED_OUT=0
  - CYCLES=0, HALT_q=0, hold/drain counter=0
- All outputs are decoded from registered state; there are no combinational paths from inputs to outputs.
- HALT edge detection:
  - HALT_q registers HALT every cycle.
  - halt_edge = HALT & ~HALT_q, qualified only in RUN.
  - A HALT already high when RUN is entered is not an edge. HALT_q is forced to 1 on RUN entry whenever HALT is high, so a stale HALT from the previous run is ignored.
- IDLE: CPU_RST_bar=0.
  - START=1 -> RESET_HOLD, hold counter loaded with RESET_CYCLES-1.
- RESET_HOLD: CPU_RST_bar=0. Counter decrements each cycle.
  - At 0 -> RUN, with CPU_RST_bar=1 and CYCLES=0 in the same edge.
  - Exactly RESET_CYCLES cycles of CPU_RST_bar low are observed after the START-sampling edge.
- RUN: CPU_RST_bar=1. CYCLES increments by 1 every cycle and saturates at all-ones (no wrap).
  - halt_edge with POST_HALT_CYCLES>0 -> DRAIN, counter loaded with POST_HALT_CYCLES-1.
  - halt_edge with POST_HALT_CYCLES=0 -> DONE.
  - Otherwise, if TIMEOUT_CYCLES!=0 and CYCLES==TIMEOUT_CYCLES-1 -> TIMEOUT.
  - halt_edge and the timeout condition in the same cycle: halt wins.
  - START is ignored in RUN.
- DRAIN: CPU_RST_bar=1. CYCLES keeps counting. Counter decrements each cycle.
  - At 0 -> DONE.
  - HALT falling or re-rising is ignored.
  - The timeout does not apply.
  - START is ignored.
- DONE: CPU_RST_bar=1 (the processor stays halted, not reset). CYCLES is frozen.
  - START -> RESET_HOLD.
- TIMEOUT: CPU_RST_bar=0. CYCLES is frozen at TIMEOUT_CYCLES.
  - START -> RESET_HOLD.
- The frozen CYCLES value is cleared only on the RESET_HOLD->RUN transition, so it remains readable until the next run starts.

Decomposition:
- Package run_controller_pkg contains:
  - typedef enum logic [2:0] state_t: IDLE, RESET_HOLD, RUN, DRAIN, DONE, TIMEOUT.
  - A localparam function giving the hold/drain counter width: clog2 of max(RESET_CYCLES, POST_HALT_CYCLES, 2).
- One sub-module, sat_counter: a parameterized-width up-counter with sync clear, enable and saturation, used for CYCLES.
- The FSM and the down-counter live in run_controller itself.

Test Plan:
- Release after reset: RST_bar low 3 cycles, then START pulse for 1 cycle -> CPU_RST_bar low for exactly 10 cycles, then high; RUNNING=1; CYCLES=0 on the first run cycle.
- Halt and drain: HALT rises 40 cycles after release -> RUNNING stays high 5 more cycles; then DONE=1, RUNNING=0, CPU_RST_bar=1; CYCLES frozen at 45.
- Timeout: TIMEOUT_CYCLES=100, HALT held low -> TIMED_OUT=1 and CPU_RST_bar=0 exactly 100 cycles after release; CYCLES=100.
- Stale HALT: HALT held high from the previous run through a restart (START in DONE) -> no DONE until HALT falls and rises again; START pulses during RUN/DRAIN are ignored.
- Tie and POST_HALT_CYCLES=0: HALT edge on cycle 99 with TIMEOUT_CYCLES=100 -> DONE, not TIMEOUT; DONE on the cycle after the edge.
- Mid-run reset: RST_bar low for 1 cycle during DRAIN -> next edge IDLE, all outputs 0, CYCLES=0; a following START behaves as in the first scenario.

Source files
------------

// File: rtl/run_controller_pkg.sv
// Shared types and sizing helpers for the processor run/halt supervisor.
package run_controller_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RESET_HOLD,
    RUN,
    DRAIN,
    DONE,
    TIMEOUT
  } state_t;

  // Width of the shared hold/drain down-counter; never narrower than one bit.
  function automatic int cnt_width(input int reset_cycles, input int post_halt_cycles);
    int m;
    m = reset_cycles;
    if (post_halt_cycles > m) m = post_halt_cycles;
    if (m < 2) m = 2;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_bar,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge CLK) begin
    if (!RST_bar) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/run_controller.sv
// Run/halt supervisor: holds the processor in reset, runs it, drains after HALT,
// and reports DONE or TIMEOUT.
//
// state      | meaning
// IDLE       | after reset, processor held in reset, waiting for START
// RESET_HOLD | processor held in reset for RESET_CYCLES cycles
// RUN        | processor running, watching for a HALT rising edge or timeout
// DRAIN      | HALT seen, processor keeps running POST_HALT_CYCLES cycles
// DONE       | run finished normally, processor halted but out of reset
// TIMEOUT    | HALT never arrived, processor forced back into reset
module run_controller #(
  parameter int RESET_CYCLES     = 10,
  parameter int POST_HALT_CYCLES = 5,
  parameter int TIMEOUT_CYCLES   = 2500000,
  parameter int CYCLE_WIDTH      = 32
) (
  input  logic                   CLK,
  input  logic                   RST_bar,
  input  logic                   START,
  input  logic                   HALT,
  output logic                   CPU_RST_bar,
  output logic                   RUNNING,
  output logic                   DONE,
  output logic                   TIMED_OUT,
  output logic [CYCLE_WIDTH-1:0] CYCLES
);
  import run_controller_pkg::*;

  localparam int CW = cnt_width(RESET_CYCLES, POST_HALT_CYCLES);
  localparam logic [CW-1:0] HOLD_LOAD  = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(POST_HALT_CYCLES - 1);
  localparam logic [CYCLE_WIDTH-1:0] TO_LAST = CYCLE_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            halt_q;
  logic            halt_edge;
  logic            cyc_clear;
  logic            cyc_en;
  logic            cpu_rst_bar_q;

  // halt_q tracks HALT through RESET_HOLD, so a HALT still high on RUN entry is not an edge.
  always_ff @(posedge CLK) begin
    if (!RST_bar) begin
      state         <= IDLE;
      cnt           <= '0;
      halt_q        <= 1'b0;
      cpu_rst_bar_q <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      halt_q        <= HALT;
      cpu_rst_bar_q <= (state_nxt == RUN) || (state_nxt == DRAIN) ||
                       (state_nxt == run_controller_pkg::DONE);
    end
  end

  assign halt_edge = HALT && !halt_q && (state == RUN);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cyc_clear = 1'b0;
    case (state)
      IDLE, run_controller_pkg::DONE, TIMEOUT: begin
        if (START) begin
          state_nxt = RESET_HOLD;
          cnt_nxt   = HOLD_LOAD;
        end
      end
      RESET_HOLD: begin
        if (cnt == '0) begin
          state_nxt = RUN;
          cyc_clear = 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      RUN: begin
        // A HALT edge takes priority over a timeout landing on the same cycle.
        if (halt_edge) begin
          if (POST_HALT_CYCLES > 0) begin
            state_nxt = DRAIN;
            cnt_nxt   = DRAIN_LOAD;
          end else begin
            state_nxt = run_controller_pkg::DONE;
          end
        end else if ((TIMEOUT_CYCLES != 0) && (CYCLES == TO_LAST)) begin
          state_nxt = TIMEOUT;
        end
      end
      DRAIN: begin
        if (cnt == '0) begin
          state_nxt = run_controller_pkg::DONE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cyc_en = (state == RUN) || (state == DRAIN);

  sat_counter #(
    .WIDTH(CYCLE_WIDTH)
  ) u_cycles (
    .CLK     (CLK),
    .RST_bar (RST_bar),
    .clear   (cyc_clear),
    .enable  (cyc_en),
    .count   (CYCLES)
  );

  assign CPU_RST_bar = cpu_rst_bar_q;
  assign RUNNING     = (state == RUN) || (state == DRAIN);
  assign DONE        = (state == run_controller_pkg::DONE);
  assign TIMED_OUT   = (state == TIMEOUT);

endmodule

// File: tb/tb_run_controller.sv
// Randomized bench for run_controller: three configurations share stimulus and are
// checked every cycle against a run-level arithmetic model.
module tb_run_controller;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RST_bar, START, HALT;

  logic cpu_a, run_a, dn_a, to_a;
  logic cpu_b, run_b, dn_b, to_b;
  logic cpu_c, run_c, dn_c, to_c;
  logic [31:0] cyc_a, cyc_b;
  logic [3:0]  cyc_c;

  run_controller #(.RESET_CYCLES(10), .POST_HALT_CYCLES(5), .TIMEOUT_CYCLES(100), .CYCLE_WIDTH(32)) u_a (
    .CLK(CLK), .RST_bar(RST_bar), .START(START), .HALT(HALT),
    .CPU_RST_bar(cpu_a), .RUNNING(run_a), .DONE(dn_a), .TIMED_OUT(to_a), .CYCLES(cyc_a));

  run_controller #(.RESET_CYCLES(10), .POST_HALT_CYCLES(0), .TIMEOUT_CYCLES(100), .CYCLE_WIDTH(32)) u_b (
    .CLK(CLK), .RST_bar(RST_bar), .START(START), .HALT(HALT),
    .CPU_RST_bar(cpu_b), .RUNNING(run_b), .DONE(dn_b), .TIMED_OUT(to_b), .CYCLES(cyc_b));

  run_controller #(.RESET_CYCLES(1), .POST_HALT_CYCLES(2), .TIMEOUT_CYCLES(0), .CYCLE_WIDTH(4)) u_c (
    .CLK(CLK), .RST_bar(RST_bar), .START(START), .HALT(HALT),
    .CPU_RST_bar(cpu_c), .RUNNING(run_c), .DONE(dn_c), .TIMED_OUT(to_c), .CYCLES(cyc_c));

  int checks = 0;
  int errors = 0;

  int pr[3] = '{10, 10, 1};
  int pp[3] = '{5, 0, 2};
  int pt[3] = '{100, 100, 0};
  longint cmax[3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 15};
  logic [31:0] prev_cyc[3];

  // Current run description: HALT level as a function of edges since the START edge.
  int  rise_k, fall_k;
  bit  stale;
  int  m_kind[3];
  int  m_nfin[3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit hv(input int k);
    if (stale) return (k < fall_k) || (k >= rise_k);
    return k >= rise_k;
  endfunction

  // kind 1: halt edge at run cycle n, DONE after n+P; kind 2: timeout at T.
  task automatic model_end(input int r, input int p, input int t, output int kind, output int nfin);
    kind = 0;
    nfin = 0;
    for (int n = 1; n <= 400; n++) begin
      if (hv(r + n) && !hv(r + n - 1)) begin
        kind = 1;
        nfin = n + p;
        return;
      end
      if (t != 0 && n == t) begin
        kind = 2;
        nfin = t;
        return;
      end
    end
  endtask

  function automatic logic [31:0] sat(input int i, input int n);
    if (longint'(n) > cmax[i]) return cmax[i][31:0];
    return n;
  endfunction

  task automatic expect_at(input int i, input int k, output logic c, output logic r,
                           output logic d, output logic t, output logic [31:0] y);
    int n;
    c = 1'b0; r = 1'b0; d = 1'b0; t = 1'b0; y = prev_cyc[i];
    if (k >= pr[i]) begin
      n = k - pr[i];
      if (m_kind[i] == 1 && n >= m_nfin[i]) begin
        c = 1'b1; d = 1'b1; y = sat(i, m_nfin[i]);
      end else if (m_kind[i] == 2 && n >= m_nfin[i]) begin
        t = 1'b1; y = m_nfin[i];
      end else begin
        c = 1'b1; r = 1'b1; y = sat(i, n);
      end
    end
  endtask

  task automatic get_obs(input int i, output logic c, output logic r, output logic d,
                         output logic t, output logic [31:0] y);
    case (i)
      0:       begin c = cpu_a; r = run_a; d = dn_a; t = to_a; y = cyc_a; end
      1:       begin c = cpu_b; r = run_b; d = dn_b; t = to_b; y = cyc_b; end
      default: begin c = cpu_c; r = run_c; d = dn_c; t = to_c; y = {28'd0, cyc_c}; end
    endcase
  endtask

  task automatic check_outputs(input string where, input int i, input logic ec, input logic er,
                               input logic ed, input logic et, input logic [31:0] ey);
    logic c, r, d, t;
    logic [31:0] y;
    get_obs(i, c, r, d, t, y);
    check($sformatf("%s u%0d cpu_rst_bar", where, i), {31'd0, c}, {31'd0, ec});
    check($sformatf("%s u%0d running", where, i), {31'd0, r}, {31'd0, er});
    check($sformatf("%s u%0d done", where, i), {31'd0, d}, {31'd0, ed});
    check($sformatf("%s u%0d timed_out", where, i), {31'd0, t}, {31'd0, et});
    check($sformatf("%s u%0d cycles", where, i), y, ey);
  endtask

  task automatic check_reset_state(input string where);
    for (int i = 0; i < 3; i++) check_outputs(where, i, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  // One START-initiated run; rst_at >= 0 pulses RST_bar at that edge and ends the run.
  task automatic run_once(input int rk, input int fk, input bit st, input int rst_at, input bit ign);
    int kmax, minfin, ign_k, e;
    logic c, r, d, t;
    logic [31:0] y;
    rise_k = rk;
    fall_k = fk;
    stale  = st;
    kmax   = 0;
    minfin = 1000000;
    for (int i = 0; i < 3; i++) begin
      model_end(pr[i], pp[i], pt[i], m_kind[i], m_nfin[i]);
      e = pr[i] + m_nfin[i];
      if (e > kmax) kmax = e;
      if (e < minfin) minfin = e;
    end
    kmax  = kmax + 2;
    ign_k = ign ? int'($urandom_range(minfin, 1)) : -1;
    for (int k = 0; k <= kmax; k++) begin
      START   = (k == 0) || (k == ign_k);
      HALT    = hv(k);
      RST_bar = (k != rst_at);
      @(posedge CLK);
      #1;
      if (k == rst_at) begin
        START   = 1'b0;
        RST_bar = 1'b1;
        check_reset_state($sformatf("rst k%0d", k));
        for (int i = 0; i < 3; i++) prev_cyc[i] = 32'd0;
        for (int j = 0; j < 2; j++) begin
          @(posedge CLK);
          #1;
          check_reset_state("idle after rst");
        end
        return;
      end
      for (int i = 0; i < 3; i++) begin
        expect_at(i, k, c, r, d, t, y);
        check_outputs($sformatf("k%0d", k), i, c, r, d, t, y);
      end
    end
    START = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_at(i, kmax, c, r, d, t, y);
      prev_cyc[i] = y;
    end
  endtask

  initial begin
    int rk, fk, ra;
    bit st;
    RST_bar = 1'b0;
    START   = 1'b0;
    HALT    = 1'b0;
    for (int i = 0; i < 3; i++) prev_cyc[i] = 32'd0;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_state("reset");
    RST_bar = 1'b1;
    @(posedge CLK);
    #1;
    check_reset_state("idle");

    run_once(50, 0, 1'b0, -1, 1'b0);   // halt 40 cycles after release, drain to 45
    run_once(80, 60, 1'b1, -1, 1'b1);  // stale HALT, START pulse ignored mid-run
    run_once(125, 0, 1'b0, -1, 1'b0);  // timeout for u0/u1 at 100
    run_once(110, 0, 1'b0, -1, 1'b0);  // halt edge and timeout tie
    run_once(50, 0, 1'b0, 52, 1'b0);   // reset during drain
    run_once(50, 0, 1'b0, -1, 1'b0);   // clean restart after reset

    for (int n = 0; n < 10; n++) begin
      rk = int'($urandom_range(200, 15));
      st = 1'($urandom_range(1, 0));
      fk = int'($urandom_range(rk - 1, 0));
      ra = ($urandom_range(5, 0) == 0) ? int'($urandom_range(rk, 1)) : -1;
      run_once(rk, fk, st, ra, 1'($urandom_range(1, 0)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
